// File: rtl/ce_pulse_gen_pkg.sv
// ce_pulse_gen shared definitions
// State encoding and default datapath width.
package ce_pulse_gen_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ce_phase_counter.sv
// ce_phase_counter: loadable down-counter
// Counts cycles between CE pulses; zero flag marks a pulse slot.
module ce_phase_counter
  import ce_pulse_gen_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [width-1:0] i_load_val,
  output logic             o_zero
);

  logic [width-1:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ce_pulse_gen.sv
// ce_pulse_gen: programmable CE strobe sequencer
// Issues COUNT pulses spaced PERIOD cycles apart (COUNT=0: free-run).
module ce_pulse_gen
  import ce_pulse_gen_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic [width-1:0] PERIOD,
  input  logic [width-1:0] COUNT,
  output logic             CE,
  output logic             BUSY,
  output logic             DONE,
  output logic [width-1:0] PULSES
);

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_ce;
  logic             w_ce_nx;
  logic             r_done;
  logic             w_done_nx;
  logic [width-1:0] r_pulses;
  logic [width-1:0] w_pulses_nx;
  logic [width-1:0] r_cnt;
  logic [width-1:0] w_cnt_nx;
  logic [width-1:0] r_per;
  logic [width-1:0] w_per_nx;
  logic [width-1:0] w_in_per;
  logic [width-1:0] w_ph_val;
  logic             w_ph_load;
  logic             w_ph_en;
  logic             w_ph_zero;
  logic             w_last;

  // Reload value is P'-1; a zero period behaves like one.
  assign w_in_per = (PERIOD == '0) ? '0 : PERIOD - 1'b1;

  // Final pulse of a bounded run was issued last cycle.
  assign w_last = r_ce && (r_cnt != '0) && (r_pulses == r_cnt);

  ce_phase_counter #(
    .width(width)
  ) u_phase (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_load    (w_ph_load),
    .i_en      (w_ph_en),
    .i_load_val(w_ph_val),
    .o_zero    (w_ph_zero)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nx  = r_state;
    w_ce_nx     = 1'b0;
    w_done_nx   = 1'b0;
    w_pulses_nx = r_pulses;
    w_cnt_nx    = r_cnt;
    w_per_nx    = r_per;
    w_ph_load   = 1'b0;
    w_ph_en     = 1'b0;
    w_ph_val    = r_per;
    unique case (r_state)
      IDLE: begin
        if (START && !STOP) begin
          w_state_nx  = RUN;
          w_ce_nx     = 1'b1;
          w_pulses_nx = {{(width-1){1'b0}}, 1'b1};
          w_cnt_nx    = COUNT;
          w_per_nx    = w_in_per;
          w_ph_load   = 1'b1;
          w_ph_val    = w_in_per;
        end
      end
      RUN: begin
        if (STOP || w_last) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end else if (w_ph_zero) begin
          if ((r_cnt == '0) || (r_pulses < r_cnt)) begin
            w_ce_nx     = 1'b1;
            w_pulses_nx = r_pulses + 1'b1;
            w_ph_load   = 1'b1;
          end else begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end
        end else begin
          w_ph_en = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_ce     <= 1'b0;
      r_done   <= 1'b0;
      r_pulses <= '0;
      r_cnt    <= '0;
      r_per    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_ce     <= w_ce_nx;
      r_done   <= w_done_nx;
      r_pulses <= w_pulses_nx;
      r_cnt    <= w_cnt_nx;
      r_per    <= w_per_nx;
    end
  end

  assign CE     = r_ce;
  assign BUSY   = (r_state == RUN);
  assign DONE   = r_done;
  assign PULSES = r_pulses;

endmodule

// File: tb/tb_ce_pulse_gen.sv
// tb_ce_pulse_gen: directed vector bench
// Per-cycle input/expected-output table plus a narrow-width wrap run.
module tb_ce_pulse_gen;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] per;
    logic [15:0] cnt;
    logic        ce;
    logic        busy;
    logic        done;
    logic [15:0] pulses;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] per;
  logic [15:0] cnt;
  logic        ce;
  logic        busy;
  logic        done;
  logic [15:0] pulses;

  logic        start2;
  logic        stop2;
  logic [3:0]  per2;
  logic [3:0]  cnt2;
  logic        ce2;
  logic        busy2;
  logic        done2;
  logic [3:0]  pulses2;

  int n_vec = 0;
  int n_bad = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  ce_pulse_gen #(.width(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .START (start),
    .STOP  (stop),
    .PERIOD(per),
    .COUNT (cnt),
    .CE    (ce),
    .BUSY  (busy),
    .DONE  (done),
    .PULSES(pulses)
  );

  ce_pulse_gen #(.width(4)) dut4 (
    .CLK   (clk),
    .RESET (rst),
    .START (start2),
    .STOP  (stop2),
    .PERIOD(per2),
    .COUNT (cnt2),
    .CE    (ce2),
    .BUSY  (busy2),
    .DONE  (done2),
    .PULSES(pulses2)
  );

  function automatic vec_t mk(
    input logic r, s, p,
    input int pr, c,
    input logic e, b, d,
    input int np
  );
    vec_t v;
    v.rst    = r;
    v.start  = s;
    v.stop   = p;
    v.per    = 16'(pr);
    v.cnt    = 16'(c);
    v.ce     = e;
    v.busy   = b;
    v.done   = d;
    v.pulses = 16'(np);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [18:0] act,
    input logic [18:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ce/busy/done/pulses=%b/%b/%b/%0d want %b/%b/%b/%0d",
               nm, act[18], act[17], act[16], act[15:0],
               exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    per    = '0;
    cnt    = '0;
    start2 = 1'b0;
    stop2  = 1'b0;
    per2   = '0;
    cnt2   = '0;

    // reset
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
    // periodic burst P=3 C=4, PERIOD/COUNT changed mid-run
    tbl.push_back(mk(0,1,0,3,4, 1,1,0,1));
    tbl.push_back(mk(0,0,0,3,4, 0,1,0,1));
    tbl.push_back(mk(0,0,0,7,9, 0,1,0,1));
    tbl.push_back(mk(0,0,0,7,9, 1,1,0,2));
    tbl.push_back(mk(0,0,0,7,9, 0,1,0,2));
    tbl.push_back(mk(0,0,0,7,9, 0,1,0,2));
    tbl.push_back(mk(0,0,0,7,9, 1,1,0,3));
    tbl.push_back(mk(0,0,0,7,9, 0,1,0,3));
    tbl.push_back(mk(0,0,0,7,9, 0,1,0,3));
    tbl.push_back(mk(0,0,0,7,9, 1,1,0,4));
    tbl.push_back(mk(0,0,0,7,9, 0,0,1,4));
    tbl.push_back(mk(0,0,0,7,9, 0,0,0,4));
    // zero period P=0 C=3
    tbl.push_back(mk(0,1,0,0,3, 1,1,0,1));
    tbl.push_back(mk(0,0,0,0,3, 1,1,0,2));
    tbl.push_back(mk(0,0,0,0,3, 1,1,0,3));
    tbl.push_back(mk(0,0,0,0,3, 0,0,1,3));
    tbl.push_back(mk(0,0,0,0,3, 0,0,0,3));
    // START and STOP together in IDLE
    tbl.push_back(mk(0,1,1,2,2, 0,0,0,3));
    tbl.push_back(mk(0,0,0,2,2, 0,0,0,3));
    // free-run P=2 then stop
    tbl.push_back(mk(0,1,0,2,0, 1,1,0,1));
    tbl.push_back(mk(0,0,0,2,0, 0,1,0,1));
    tbl.push_back(mk(0,0,0,2,0, 1,1,0,2));
    tbl.push_back(mk(0,0,0,2,0, 0,1,0,2));
    tbl.push_back(mk(0,0,0,2,0, 1,1,0,3));
    tbl.push_back(mk(0,0,0,2,0, 0,1,0,3));
    tbl.push_back(mk(0,0,0,2,0, 1,1,0,4));
    tbl.push_back(mk(0,0,0,2,0, 0,1,0,4));
    tbl.push_back(mk(0,0,0,2,0, 1,1,0,5));
    tbl.push_back(mk(0,0,1,2,0, 0,0,1,5));
    tbl.push_back(mk(0,0,0,2,0, 0,0,0,5));
    // back-to-back restart P=1 C=2, START held
    tbl.push_back(mk(0,1,0,1,2, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,2, 1,1,0,2));
    tbl.push_back(mk(0,1,0,1,2, 0,0,1,2));
    tbl.push_back(mk(0,1,0,1,2, 1,1,0,1));
    tbl.push_back(mk(0,1,0,1,2, 1,1,0,2));
    tbl.push_back(mk(0,0,0,1,2, 0,0,1,2));
    tbl.push_back(mk(0,0,0,1,2, 0,0,0,2));
    // reset mid-run P=2 C=8, then a fresh P=1 C=1 run
    tbl.push_back(mk(0,1,0,2,8, 1,1,0,1));
    tbl.push_back(mk(0,0,0,2,8, 0,1,0,1));
    tbl.push_back(mk(0,0,0,2,8, 1,1,0,2));
    tbl.push_back(mk(0,0,0,2,8, 0,1,0,2));
    tbl.push_back(mk(1,0,0,2,8, 0,0,0,0));
    tbl.push_back(mk(0,0,0,2,8, 0,0,0,0));
    tbl.push_back(mk(0,0,0,2,8, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1,1, 1,1,0,1));
    tbl.push_back(mk(0,0,0,1,1, 0,0,1,1));
    tbl.push_back(mk(0,0,0,1,1, 0,0,0,1));
    // STOP in IDLE has no effect
    tbl.push_back(mk(0,0,1,1,1, 0,0,0,1));

    #1;
    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      stop  = tbl[i].stop;
      per   = tbl[i].per;
      cnt   = tbl[i].cnt;
      tick();
      chk($sformatf("vec%0d", i), {ce, busy, done, pulses},
          {tbl[i].ce, tbl[i].busy, tbl[i].done, tbl[i].pulses});
    end
    start = 1'b0;
    stop  = 1'b0;

    // width=4 free-run at period 1: PULSES wraps while CE stays high
    begin
      logic [3:0] e;
      start2 = 1'b1;
      per2   = 4'd1;
      cnt2   = 4'd0;
      tick();
      start2 = 1'b0;
      e = 4'd1;
      chk("wrap_start", {ce2, busy2, done2, 12'd0, pulses2},
          {1'b1, 1'b1, 1'b0, 12'd0, e});
      for (int k = 0; k < 19; k++) begin
        tick();
        e = e + 4'd1;
        chk($sformatf("wrap%0d", k), {ce2, busy2, done2, 12'd0, pulses2},
            {1'b1, 1'b1, 1'b0, 12'd0, e});
      end
      stop2 = 1'b1;
      tick();
      stop2 = 1'b0;
      chk("wrap_stop", {ce2, busy2, done2, 12'd0, pulses2},
          {1'b0, 1'b0, 1'b1, 12'd0, e});
      tick();
      chk("wrap_hold", {ce2, busy2, done2, 12'd0, pulses2},
          {1'b0, 1'b0, 1'b0, 12'd0, e});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
